// File: rtl/mem_pkg.sv
// Shared types and constants for the I/D memory arbiter.
// Default widths match the core's word and cache-line sizes.
package mem_pkg;

   localparam int WORD_SIZE_DEF    = 32;
   localparam int LINE_SIZE_DEF    = 128;
   localparam int LINE_OFFSET_BITS = $clog2(LINE_SIZE_DEF / 8);

   typedef enum logic [1:0] {SRC_I, SRC_DR, SRC_DW} src_e;
   typedef enum logic       {IDLE, WAIT}             state_e;

   function automatic logic [WORD_SIZE_DEF-1:0] line_align(input logic [WORD_SIZE_DEF-1:0] a);
      return {a[WORD_SIZE_DEF-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response and memory-side bus of the arbiter.
// slave = arbiter view, master = the core/memory environment.
interface mem_arbiter_if
   import mem_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int LINE_SIZE = LINE_SIZE_DEF
);
   logic                 i_read;
   logic [WORD_SIZE-1:0] i_addr;
   logic                 i_res;
   logic [LINE_SIZE-1:0] i_res_data;
   logic [WORD_SIZE-1:0] i_res_addr;
   logic                 d_read;
   logic [WORD_SIZE-1:0] d_addr;
   logic                 d_res;
   logic [LINE_SIZE-1:0] d_res_data;
   logic [WORD_SIZE-1:0] d_res_addr;
   logic                 d_wenable;
   logic [LINE_SIZE-1:0] d_w_data;
   logic [WORD_SIZE-1:0] d_w_addr;
   logic                 m_req;
   logic                 m_we;
   logic [WORD_SIZE-1:0] m_addr;
   logic [LINE_SIZE-1:0] m_wdata;
   logic                 m_res;
   logic [LINE_SIZE-1:0] m_rdata;
   logic                 overflow;

   modport slave (
      input  i_read, i_addr, d_read, d_addr, d_wenable, d_w_data, d_w_addr, m_res, m_rdata,
      output i_res, i_res_data, i_res_addr, d_res, d_res_data, d_res_addr,
             m_req, m_we, m_addr, m_wdata, overflow
   );

   modport master (
      output i_read, i_addr, d_read, d_addr, d_wenable, d_w_data, d_w_addr, m_res, m_rdata,
      input  i_res, i_res_data, i_res_addr, d_res, d_res_data, d_res_addr,
             m_req, m_we, m_addr, m_wdata, overflow
   );
endinterface

// File: rtl/req_slot.sv
// One-deep pending request register: line-aligned address, optional line data,
// refill allowed in the cycle the slot is granted, overflow flagged otherwise.
module req_slot #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 128,
   parameter int OFF_BITS = 4,
   parameter bit HAS_DATA = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_i,
   input  logic              clr_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic              ovf_o
);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              accept;

   assign accept = set_i && (!valid_q || clr_i);
   assign ovf_o  = set_i && valid_q && !clr_i;

   // NOTE: every always_comb output gets its hold value first, so no path infers a latch.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      if (clr_i)  valid_d = 1'b0;
      if (accept) begin
         valid_d = 1'b1;
         addr_d  = addr_i & ALIGN_MASK;
      end
   end

   // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

   if (HAS_DATA) begin : g_data
      logic [DATA_W-1:0] data_q;
      // NOTE: the data register is reset too, so a never-written slot reads as zero.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)         data_q <= '0;
         else if (accept) data_q <= data_i;
      end
      assign data_o = data_q;
   end else begin : g_no_data
      logic unused_data;
      assign unused_data = ^data_i;
      assign data_o      = '0;
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache reads, D-cache reads and D-cache writebacks onto one
// line-wide memory port, one transaction in flight, round-robin I vs D group.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int LINE_SIZE = LINE_SIZE_DEF
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam int OFF_BITS = $clog2(LINE_SIZE / 8);

   logic                 pi_valid, pdr_valid, pdw_valid;
   logic [WORD_SIZE-1:0] pi_addr, pdr_addr, pdw_addr;
   logic [LINE_SIZE-1:0] pdw_data;
   logic                 pi_data_unused, pdr_data_unused;
   logic                 ovf_i, ovf_dr, ovf_dw;
   logic                 clr_i, clr_dr, clr_dw;

   state_e               state_q, state_d;
   src_e                 src_q, src_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic                 rr_d_q, rr_d_d;  // 1: D group is favoured at the next contested grant
   logic                 overflow_q;

   logic                 m_req_c, m_we_c;
   logic [WORD_SIZE-1:0] m_addr_c;
   logic [LINE_SIZE-1:0] m_wdata_c;
   logic                 i_cap, d_cap;

   logic                 i_res_q, d_res_q;
   logic [LINE_SIZE-1:0] i_res_data_q, d_res_data_q;
   logic [WORD_SIZE-1:0] i_res_addr_q, d_res_addr_q;

   req_slot #(.ADDR_W(WORD_SIZE), .DATA_W(1), .OFF_BITS(OFF_BITS), .HAS_DATA(1'b0)) u_pi (
      .clk(clk), .rst(rst), .set_i(bus.i_read), .clr_i(clr_i), .addr_i(bus.i_addr),
      .data_i(1'b0), .valid_o(pi_valid), .addr_o(pi_addr), .data_o(pi_data_unused), .ovf_o(ovf_i));

   req_slot #(.ADDR_W(WORD_SIZE), .DATA_W(1), .OFF_BITS(OFF_BITS), .HAS_DATA(1'b0)) u_pdr (
      .clk(clk), .rst(rst), .set_i(bus.d_read), .clr_i(clr_dr), .addr_i(bus.d_addr),
      .data_i(1'b0), .valid_o(pdr_valid), .addr_o(pdr_addr), .data_o(pdr_data_unused), .ovf_o(ovf_dr));

   req_slot #(.ADDR_W(WORD_SIZE), .DATA_W(LINE_SIZE), .OFF_BITS(OFF_BITS), .HAS_DATA(1'b1)) u_pdw (
      .clk(clk), .rst(rst), .set_i(bus.d_wenable), .clr_i(clr_dw), .addr_i(bus.d_w_addr),
      .data_i(bus.d_w_data), .valid_o(pdw_valid), .addr_o(pdw_addr), .data_o(pdw_data), .ovf_o(ovf_dw));

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      addr_d    = addr_q;
      rr_d_d    = rr_d_q;
      clr_i     = 1'b0;
      clr_dr    = 1'b0;
      clr_dw    = 1'b0;
      m_req_c   = 1'b0;
      m_we_c    = 1'b0;
      m_addr_c  = '0;
      m_wdata_c = '0;
      i_cap     = 1'b0;
      d_cap     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pi_valid && (!(pdw_valid || pdr_valid) || !rr_d_q)) begin
               m_req_c  = 1'b1;
               m_addr_c = pi_addr;
               clr_i    = 1'b1;
               src_d    = SRC_I;
               rr_d_d   = 1'b1;
            end else if (pdw_valid) begin
               // Writeback ahead of the D read keeps read-after-writeback coherent.
               m_req_c   = 1'b1;
               m_we_c    = 1'b1;
               m_addr_c  = pdw_addr;
               m_wdata_c = pdw_data;
               clr_dw    = 1'b1;
               src_d     = SRC_DW;
               rr_d_d    = 1'b0;
            end else if (pdr_valid) begin
               m_req_c  = 1'b1;
               m_addr_c = pdr_addr;
               clr_dr   = 1'b1;
               src_d    = SRC_DR;
               rr_d_d   = 1'b0;
            end
            if (m_req_c) begin
               addr_d  = m_addr_c;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.m_res) begin
               i_cap   = (src_q == SRC_I);
               d_cap   = (src_q == SRC_DR);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         src_q        <= SRC_I;
         addr_q       <= '0;
         rr_d_q       <= 1'b0;
         overflow_q   <= 1'b0;
         i_res_q      <= 1'b0;
         i_res_data_q <= '0;
         i_res_addr_q <= '0;
         d_res_q      <= 1'b0;
         d_res_data_q <= '0;
         d_res_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         addr_q     <= addr_d;
         rr_d_q     <= rr_d_d;
         overflow_q <= overflow_q | ovf_i | ovf_dr | ovf_dw;
         i_res_q    <= i_cap;
         d_res_q    <= d_cap;
         if (i_cap) begin
            i_res_data_q <= bus.m_rdata;
            i_res_addr_q <= addr_q;
         end
         if (d_cap) begin
            d_res_data_q <= bus.m_rdata;
            d_res_addr_q <= addr_q;
         end
      end
   end

   assign bus.m_req      = m_req_c;
   assign bus.m_we       = m_we_c;
   assign bus.m_addr     = m_addr_c;
   assign bus.m_wdata    = m_wdata_c;
   assign bus.i_res      = i_res_q;
   assign bus.i_res_data = i_res_data_q;
   assign bus.i_res_addr = i_res_addr_q;
   assign bus.d_res      = d_res_q;
   assign bus.d_res_data = d_res_data_q;
   assign bus.d_res_addr = d_res_addr_q;
   assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected memory
// requests and responses; a monitor pops and compares whenever the DUT presents one.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int W = 32;
   localparam int L = 128;

   typedef struct {
      logic         we;
      logic [W-1:0] addr;
      logic [L-1:0] wdata;
   } mreq_t;

   typedef struct {
      logic [W-1:0] addr;
      logic [L-1:0] data;
   } resp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   mres_edge = 0;
   int   mem_lat = 3;
   bit   mem_busy = 1'b0;

   mreq_t exp_m[$];
   resp_t exp_i[$];
   resp_t exp_d[$];
   logic [L-1:0] mem [logic [W-1:0]];

   mreq_t        em;
   resp_t        er;
   logic         r_we;
   logic [W-1:0] r_addr;
   logic [L-1:0] r_wdata;

   mem_arbiter_if #(.WORD_SIZE(W), .LINE_SIZE(L)) bus ();

   mem_arbiter #(.WORD_SIZE(W), .LINE_SIZE(L)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [L-1:0] mem_default(input logic [W-1:0] a);
      return {4{a ^ 32'hDEAD_0000}};
   endfunction

   // Memory model: answers each request after mem_lat cycles, stores writes.
   always begin
      @(negedge clk);
      if (!rst && bus.m_req) begin
         r_we     = bus.m_we;
         r_addr   = bus.m_addr;
         r_wdata  = bus.m_wdata;
         mem_busy = 1'b1;
         repeat (mem_lat) @(posedge clk);
         #1;
         bus.m_res   = 1'b1;
         bus.m_rdata = r_we ? '0 : (mem.exists(r_addr) ? mem[r_addr] : mem_default(r_addr));
         if (r_we) mem[r_addr] = r_wdata;
         mres_edge = cyc + 1;
         @(posedge clk);
         #1;
         bus.m_res   = 1'b0;
         bus.m_rdata = '0;
         mem_busy    = 1'b0;
      end
   end

   // Monitor: every DUT-presented request/response is compared against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.m_req) begin
            if (exp_m.size() == 0) check("m_req_unexpected", bus.m_req, 0);
            else begin
               em = exp_m.pop_front();
               check("m_we", bus.m_we, em.we);
               check("m_addr", bus.m_addr, em.addr);
               if (em.we) check("m_wdata", bus.m_wdata, em.wdata);
            end
         end
         if (bus.i_res) begin
            if (exp_i.size() == 0) check("i_res_unexpected", bus.i_res, 0);
            else begin
               er = exp_i.pop_front();
               check("i_res_addr", bus.i_res_addr, er.addr);
               check("i_res_data", bus.i_res_data, er.data);
               check("i_res_latency", cyc, mres_edge);
            end
         end
         if (bus.d_res) begin
            if (exp_d.size() == 0) check("d_res_unexpected", bus.d_res, 0);
            else begin
               er = exp_d.pop_front();
               check("d_res_addr", bus.d_res_addr, er.addr);
               check("d_res_data", bus.d_res_data, er.data);
               check("d_res_latency", cyc, mres_edge);
            end
         end
      end
   end

   task automatic pulse(input logic ir, input logic [W-1:0] ia, input logic dr, input logic [W-1:0] da,
                        input logic dw, input logic [W-1:0] wa, input logic [L-1:0] wd);
      @(posedge clk);
      #1;
      bus.i_read = ir;  bus.i_addr = ia;
      bus.d_read = dr;  bus.d_addr = da;
      bus.d_wenable = dw;  bus.d_w_addr = wa;  bus.d_w_data = wd;
      @(posedge clk);
      #1;
      bus.i_read = 1'b0;  bus.d_read = 1'b0;  bus.d_wenable = 1'b0;
   endtask

   task automatic wait_mreq(input string name);
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 60 && !seen; t++) begin
         @(negedge clk);
         seen = bus.m_req;
      end
      check(name, seen, 1);
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while ((exp_m.size() != 0 || exp_i.size() != 0 || exp_d.size() != 0 || mem_busy) && t < 400) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      check(name, exp_m.size() + exp_i.size() + exp_d.size(), 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      @(negedge clk);
      check({tag, "_m_req"}, bus.m_req, 0);
      check({tag, "_m_we"}, bus.m_we, 0);
      check({tag, "_m_addr"}, bus.m_addr, 0);
      check({tag, "_m_wdata"}, bus.m_wdata, 0);
      check({tag, "_i_res"}, bus.i_res, 0);
      check({tag, "_i_res_data"}, bus.i_res_data, 0);
      check({tag, "_i_res_addr"}, bus.i_res_addr, 0);
      check({tag, "_d_res"}, bus.d_res, 0);
      check({tag, "_d_res_data"}, bus.d_res_data, 0);
      check({tag, "_d_res_addr"}, bus.d_res_addr, 0);
      check({tag, "_overflow"}, bus.overflow, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [L-1:0] wb_x, wb_y;
      bus.i_read = 0;  bus.i_addr = 0;  bus.d_read = 0;  bus.d_addr = 0;
      bus.d_wenable = 0;  bus.d_w_data = 0;  bus.d_w_addr = 0;
      bus.m_res = 0;  bus.m_rdata = 0;
      wb_x = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      wb_y = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_zero_outputs("reset");

      // Single I read: request edge N, m_req in cycle N+1, 3-cycle memory.
      mem[32'h100] = {16{8'hAA}};
      mem_lat = 3;
      exp_m.push_back('{1'b0, 32'h100, '0});
      exp_i.push_back('{32'h100, {16{8'hAA}}});
      pulse(1, 32'h104, 0, 0, 0, 0, '0);
      @(negedge clk);
      check("t1_m_req_latency", bus.m_req, 1);
      wait_drain("t1_drain");

      // Read-after-writeback to the same line.
      exp_m.push_back('{1'b1, 32'h200, wb_x});
      exp_m.push_back('{1'b0, 32'h200, '0});
      exp_d.push_back('{32'h200, wb_x});
      pulse(0, 0, 1, 32'h200, 1, 32'h200, wb_x);
      wait_drain("raw_drain");

      // All three slots at once with the pointer on I: I, DW, DR.
      exp_m.push_back('{1'b0, 32'h400, '0});
      exp_m.push_back('{1'b1, 32'h900, wb_y});
      exp_m.push_back('{1'b0, 32'h810, '0});
      exp_i.push_back('{32'h400, mem_default(32'h400)});
      exp_d.push_back('{32'h810, mem_default(32'h810)});
      pulse(1, 32'h40C, 1, 32'h81F, 1, 32'h90A, wb_y);
      wait_drain("simul_drain");

      // Fairness: each side re-pulses in its own grant cycle; grants must alternate.
      mem_lat = 2;
      for (int k = 0; k < 4; k++) begin
         exp_m.push_back('{1'b0, 32'h1000 + k * 16, '0});
         exp_m.push_back('{1'b0, 32'h2000 + k * 16, '0});
         exp_i.push_back('{32'h1000 + k * 16, mem_default(32'h1000 + k * 16)});
         exp_d.push_back('{32'h2000 + k * 16, mem_default(32'h2000 + k * 16)});
      end
      pulse(1, 32'h1003, 1, 32'h2005, 0, 0, '0);
      for (int k = 0; k < 8; k++) begin
         wait_mreq("fair_grant_seen");
         if (k < 6) begin
            if (k % 2 == 0) begin
               bus.i_read = 1'b1;  bus.i_addr = 32'h1003 + (k / 2 + 1) * 16;
            end else begin
               bus.d_read = 1'b1;  bus.d_addr = 32'h2005 + (k / 2 + 1) * 16;
            end
            @(posedge clk);
            #1;
            bus.i_read = 1'b0;  bus.d_read = 1'b0;
         end else begin
            @(posedge clk);
         end
      end
      wait_drain("fair_drain");
      check("refill_no_overflow", bus.overflow, 0);

      // Overflow: three I pulses while the arbiter waits on a D read.
      mem_lat = 4;
      exp_m.push_back('{1'b0, 32'h600, '0});
      exp_m.push_back('{1'b0, 32'h700, '0});
      exp_d.push_back('{32'h600, mem_default(32'h600)});
      exp_i.push_back('{32'h700, mem_default(32'h700)});
      pulse(0, 0, 1, 32'h608, 0, 0, '0);
      wait_mreq("ovf_d_grant_seen");
      @(posedge clk);
      #1;
      bus.i_read = 1'b1;  bus.i_addr = 32'h704;
      repeat (3) @(posedge clk);
      #1 bus.i_read = 1'b0;
      @(negedge clk);
      check("overflow_set", bus.overflow, 1);
      wait_drain("ovf_drain");
      check("overflow_sticky", bus.overflow, 1);

      // Reset while waiting; the stale completion must produce nothing.
      mem_lat = 6;
      exp_m.push_back('{1'b0, 32'h500, '0});
      pulse(1, 32'h500, 0, 0, 0, 0, '0);
      wait_mreq("rst_grant_seen");
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check_zero_outputs("midrst");
      wait_drain("stale_drain");
      check_zero_outputs("stale");

      // After reset the pointer is back on I: contested I and D go I first.
      mem_lat = 3;
      exp_m.push_back('{1'b0, 32'h500, '0});
      exp_m.push_back('{1'b0, 32'h5A0, '0});
      exp_i.push_back('{32'h500, mem_default(32'h500)});
      exp_d.push_back('{32'h5A0, mem_default(32'h5A0)});
      pulse(1, 32'h504, 1, 32'h5A4, 0, 0, '0);
      wait_drain("post_rst_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, line-wide main memory between the I-cache miss port and the D-cache read/writeback ports of the core.
- Sits between `core` and a single-port `memory` in the SoC.
- Captures single-cycle requests, serialises them with one transaction outstanding, and returns registered line responses on the matching channel.

Parameters:
WORD_SIZE, `WORD_SIZE (32), address and word width in bits
LINE_SIZE, `CACHE_LINE_SIZE (128), cache line and memory data width in bits

Ports:
clk  in  1  clock
rst  in  1  reset
i_read  in  1  I-cache line read request pulse
i_addr  in  WORD_SIZE  I read address
i_res  out  1  I response pulse
i_res_data  out  LINE_SIZE  I response line
i_res_addr  out  WORD_SIZE  I response address (line-aligned)
d_read  in  1  D-cache line read request pulse
d_addr  in  WORD_SIZE  D read address
d_res  out  1  D read response pulse
d_res_data  out  LINE_SIZE  D response line
d_res_addr  out  WORD_SIZE  D response address (line-aligned)
d_wenable  in  1  D writeback request pulse
d_w_data  in  LINE_SIZE  writeback line
d_w_addr  in  WORD_SIZE  writeback address
m_req  out  1  memory request pulse
m_we  out  1  1 = write, 0 = read; valid with m_req
m_addr  out  WORD_SIZE  line-aligned memory address
m_wdata  out  LINE_SIZE  write data
m_res  in  1  memory completion pulse (reads and writes)
m_rdata  in  LINE_SIZE  read data, valid with m_res
overflow  out  1  sticky: request arrived on an already-pending channel

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - All outputs are 0, except overflow, which is 0 and sticky until reset.
  - Pending slots are cleared, state = IDLE, round-robin pointer = I.
  - Reset mid-transaction abandons the transaction; no response is issued.
  - An m_res arriving in IDLE is ignored.
- Capture:
  - Three one-deep pending slots: PI (i_read), PDR (d_read), PDW (d_wenable).
  - Each slot stores its address with the low log2(LINE_SIZE/8) bits cleared; PDW also stores the data.
  - A slot sets on its request pulse at the rising edge.
  - A pulse on an already-valid slot is dropped and sets overflow.
  - All three pulses in the same cycle are all captured.
- Arbitration, evaluated in IDLE over slots valid at the start of the cycle:
  - D group = PDW before PDR. Writeback always precedes a D read, so read-after-writeback to the same line returns the new data.
  - Round-robin between I and the D group: the pointer flips to the other side after each grant; a lone requester is granted immediately.
- FSM:
  - IDLE: if any slot is valid, drive m_req=1 for one cycle with m_we/m_addr/m_wdata of the winner, record the winner, clear its slot, go to WAIT.
  - WAIT: hold m_req=0 and wait for m_res, with no timeout.
    - On m_res for a read: register m_rdata and the address into the matching res outputs, pulse i_res or d_res the next cycle for exactly one cycle, go to IDLE.
    - On m_res for a write: go to IDLE with no upstream response.
- Latency:
  - Request pulse at edge N, idle arbiter, no competition: m_req is high in cycle N+1.
  - Memory completion at edge M: the response pulse is high in cycle M+1.
  - The next grant is possible in cycle M+1.
- A slot freed by a grant may be re-filled by a pulse in the same cycle as the grant (no overflow).
- res_data and res_addr hold their last values between pulses.

Decomposition:
- Shared package `mem_pkg`:
  - source enum {SRC_I, SRC_DR, SRC_DW};
  - FSM state enum {IDLE, WAIT};
  - LINE_OFFSET_BITS = $clog2(LINE_SIZE/8);
  - a line-align function.
- Sub-module `req_slot`: one pending register with valid, addr and optional data, set/clear logic and overflow detect. It is instantiated three times; the arbiter, FSM and response registers stay in the top level.

Test Plan:
- Single I read: i_read at cycle 0 with i_addr=0x104 -> m_req in cycle 1 with m_addr=0x100, m_we=0; memory returns 0xAA..AA after 3 cycles -> i_res for one cycle with i_res_addr=0x100, i_res_data=0xAA..AA; d_res stays 0.
- Simultaneous traffic: i_read, d_read and d_wenable in the same cycle with pointer=I -> grant order I, DW, DR.
- Read-after-writeback: d_wenable (0x200, data X) and d_read (0x200) together -> write issued first, then read; the model returns X and d_res_data=X.
- Fairness: hold d_read/i_read continuously re-pulsed -> grants strictly alternate I/D over 8 transactions, with no starvation.
- Overflow: two i_read pulses while PI is pending -> overflow=1 and remains 1; only one I transaction is issued.
- Mid-transaction reset: assert rst in WAIT, then a stale m_res arrives -> all outputs 0, no i_res/d_res, state IDLE; a subsequent i_read is served normally.
